ddram_wr_merge: RTL and testbench

DDRAM_WR_MERGE -- requirements
Module: ddram_wr_merge

---
 rtl/genesis_ddr_pkg.sv | 21 ++
 rtl/ddram_wr_merge.sv | 137 +++++++++++++
 tb/tb_ddram_wr_merge.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/genesis_ddr_pkg.sv
// Shared DDR-side definitions for the download write path: line/lane geometry,
// burst constant and the merge-buffer state encoding.
package genesis_ddr_pkg;

  localparam int DDR_LINE_W = 22;
  localparam int DDR_LANE_W = 2;
  localparam int DDR_LANES  = 4;
  localparam logic [7:0] DDR_BURSTCNT = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_ISSUE = 2'd2
  } wm_state_e;

  // Byte-enable pair covering one 16-bit lane of a 64-bit word.
  function automatic logic [7:0] lane_be(input logic [DDR_LANE_W-1:0] lane);
    return 8'b0000_0011 << {lane, 1'b0};
  endfunction

endpackage

// File: rtl/ddram_wr_merge.sv
// Collects toggle-handshaked halfword writes into one 64-bit line and issues it
// as a single Avalon-MM write when full, on a line change, on flush or when stale.
module ddram_wr_merge
  import genesis_ddr_pkg::*;
#(
  parameter logic [28:0] BASE       = 29'h0300000,
  parameter int          IDLE_FLUSH = 64
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] wraddr,
  input  logic [15:0] din,
  input  logic        we_req,
  output logic        we_ack,
  input  logic        flush,
  input  logic        DDRAM_BUSY,
  output logic        DDRAM_WE,
  output logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic        idle
);

  localparam int CNT_W = $clog2(IDLE_FLUSH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_FLUSH - 1);

  wm_state_e             state_q, state_d;
  logic [DDR_LINE_W-1:0] line_q, line_d;
  logic [63:0]           data_q, data_d;
  logic [7:0]            be_q, be_d;
  logic                  ack_q, ack_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fpend_q, fpend_d;

  logic                  pending;
  logic                  absorb;
  logic [DDR_LINE_W-1:0] req_line;
  logic [DDR_LANE_W-1:0] req_lane;
  logic [63:0]           data_m;
  logic [7:0]            be_m;
  logic                  unused_bit0;

  assign unused_bit0 = wraddr[0];
  assign req_line    = wraddr[24:3];
  assign req_lane    = wraddr[2:1];
  assign pending     = we_req ^ ack_q;

  // A flush latched behind a same-line absorb blocks further absorbs until it is served.
  assign absorb = pending &&
                  ((state_q == ST_IDLE) ||
                   (state_q == ST_MERGE && req_line == line_q && !fpend_q));

  always_comb begin
    data_m = data_q;
    data_m[16*req_lane +: 16] = din;
    be_m = be_q | lane_be(req_lane);
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    data_d  = data_q;
    be_d    = be_q;
    ack_d   = ack_q;
    cnt_d   = '0;
    fpend_d = fpend_q;
    case (state_q)
      ST_IDLE: begin
        fpend_d = 1'b0;
        if (absorb) begin
          line_d  = req_line;
          data_d  = data_m;
          be_d    = be_m;
          ack_d   = ~ack_q;
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: begin
        if (absorb) begin
          data_d = data_m;
          be_d   = be_m;
          ack_d  = ~ack_q;
          if (&be_m) begin
            state_d = ST_ISSUE;
            fpend_d = 1'b0;
          end else if (flush) begin
            fpend_d = 1'b1;
          end
        end else if (fpend_q || flush || pending || cnt_q == CNT_LAST) begin
          // Any leftover pending request here targets another line and waits.
          state_d = ST_ISSUE;
          fpend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        if (!DDRAM_BUSY) begin
          data_d  = '0;
          be_d    = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      fpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      data_q  <= data_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      fpend_q <= fpend_d;
    end
  end

  assign DDRAM_WE       = (state_q == ST_ISSUE);
  assign DDRAM_ADDR     = BASE + {7'd0, line_q};
  assign DDRAM_DIN      = data_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_BURSTCNT = DDR_BURSTCNT;
  assign we_ack         = ack_q;
  assign idle           = (state_q == ST_IDLE) && !pending;

endmodule

// File: tb/tb_ddram_wr_merge.sv
// Directed and randomized checks of the halfword write merger against a
// line-level model of which 64-bit DDR writes must appear.
module tb_ddram_wr_merge;

  localparam logic [28:0] BASE = 29'h0300000;
  localparam int IDLE_FLUSH = 64;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] wraddr;
  logic [15:0] din;
  logic        we_req;
  logic        we_ack;
  logic        flush;
  logic        DDRAM_BUSY;
  logic        DDRAM_WE;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic [7:0]  DDRAM_BURSTCNT;
  logic        idle;

  logic busy_force;
  logic busy_rand;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  be;
  } wr_t;

  wr_t exp_q[$];
  wr_t got_q[$];

  // Model: the one open line, its halfwords and which lanes were written.
  logic        m_open;
  logic [21:0] m_line;
  logic [15:0] m_hw [4];
  logic [3:0]  m_v;

  ddram_wr_merge #(.BASE(BASE), .IDLE_FLUSH(IDLE_FLUSH)) dut (
    .clk_sys(clk_sys), .reset(reset), .wraddr(wraddr), .din(din),
    .we_req(we_req), .we_ack(we_ack), .flush(flush),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_WE(DDRAM_WE), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
    .idle(idle)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys)
    DDRAM_BUSY = busy_rand ? ($urandom_range(0, 2) == 0) : busy_force;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_sys) begin
    if (!reset && DDRAM_WE && !DDRAM_BUSY) begin
      wr_t w;
      w.a = DDRAM_ADDR; w.d = DDRAM_DIN; w.be = DDRAM_BE;
      got_q.push_back(w);
      chk("be_nonzero", 64'(DDRAM_BE != 8'h00), 64'd1);
    end
  end

  function automatic void m_reset();
    m_open = 1'b0; m_v = '0; m_line = '0;
    for (int i = 0; i < 4; i++) m_hw[i] = '0;
  endfunction

  function automatic void m_emit();
    wr_t w;
    w.a  = BASE + {7'd0, m_line};
    w.d  = {m_hw[3], m_hw[2], m_hw[1], m_hw[0]};
    w.be = {{2{m_v[3]}}, {2{m_v[2]}}, {2{m_v[1]}}, {2{m_v[0]}}};
    exp_q.push_back(w);
    m_reset();
  endfunction

  function automatic void m_write(input logic [24:0] a, input logic [15:0] d);
    if (m_open && a[24:3] != m_line) m_emit();
    m_open = 1'b1;
    m_line = a[24:3];
    m_hw[a[2:1]] = d;
    m_v[a[2:1]] = 1'b1;
    if (&m_v) m_emit();
  endfunction

  function automatic void m_flush();
    if (m_open) m_emit();
  endfunction

  task automatic write_hw(input logic [24:0] a, input logic [15:0] d, output int lat);
    @(negedge clk_sys);
    wraddr = a; din = d; we_req = ~we_req;
    lat = 0;
    do begin
      @(posedge clk_sys); #1;
      lat++;
    end while (we_ack !== we_req && lat < 300);
    if (lat >= 300) chk("ack_timeout", 64'(we_ack), 64'(we_req));
  endtask

  task automatic pulse_flush();
    @(negedge clk_sys); flush = 1'b1;
    @(negedge clk_sys); flush = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 500) begin
      @(posedge clk_sys); #1; n++;
    end
    repeat (3) begin @(posedge clk_sys); #1; end
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      wr_t e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      chk({tag, "_addr"}, 64'(g.a), 64'(e.a));
      chk({tag, "_din"},  g.d, e.d);
      chk({tag, "_be"},   64'(g.be), 64'(e.be));
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    int lat;
    logic [24:0] a;
    logic [15:0] d;
    logic [63:0] din_exp;

    reset = 1'b1; wraddr = '0; din = '0; we_req = 1'b0; flush = 1'b0;
    busy_force = 1'b0; busy_rand = 1'b0;
    m_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_we",    64'(DDRAM_WE), 64'd0);
    chk("rst_be",    64'(DDRAM_BE), 64'd0);
    chk("rst_din",   DDRAM_DIN, 64'd0);
    chk("rst_addr",  64'(DDRAM_ADDR), 64'(BASE));
    chk("rst_ack",   64'(we_ack), 64'd0);
    chk("rst_idle",  64'(idle), 64'd1);
    chk("burstcnt",  64'(DDRAM_BURSTCNT), 64'd1);
    @(negedge clk_sys); reset = 1'b0;

    // Full line from four sequential halfwords.
    for (int i = 0; i < 4; i++) begin
      a = 25'(2 * i); d = 16'(16'h1111 * (i + 1));
      write_hw(a, d, lat);
      chk("full_ack_lat", 64'(lat), 64'd1);
      m_write(a, d);
    end
    check_writes("full_line");
    chk("full_idle", 64'(idle), 64'd1);

    // Line change defers the second request until the first write has gone out.
    write_hw(25'h10, 16'hABCD, lat); m_write(25'h10, 16'hABCD);
    chk("chg_lat1", 64'(lat), 64'd1);
    write_hw(25'h20, 16'h1234, lat); m_write(25'h20, 16'h1234);
    chk("chg_deferred", 64'(lat > 1), 64'd1);
    chk("chg_wr_before_ack", 64'(got_q.size()), 64'd1);
    pulse_flush(); m_flush();
    check_writes("line_change");

    // Backpressure: outputs frozen while BUSY is high.
    busy_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 25'h28 + 25'(2 * i); d = 16'hC000 + 16'(i);
      write_hw(a, d, lat); m_write(a, d);
    end
    din_exp = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      chk("busy_we",   64'(DDRAM_WE), 64'd1);
      chk("busy_addr", 64'(DDRAM_ADDR), 64'(BASE + 29'd5));
      chk("busy_din",  DDRAM_DIN, din_exp);
      chk("busy_be",   64'(DDRAM_BE), 64'hFF);
    end
    chk("busy_no_xfer", 64'(got_q.size()), 64'd0);
    busy_force = 1'b0;
    check_writes("busy_release");
    chk("busy_we_low", 64'(DDRAM_WE), 64'd0);

    // Stale partial line auto-flushes.
    write_hw(25'h0C, 16'hBEEF, lat); m_write(25'h0C, 16'hBEEF);
    lat = 0;
    do begin @(posedge clk_sys); #1; lat++; end while (!DDRAM_WE && lat < 200);
    chk("auto_flush_delay", 64'(lat), 64'(IDLE_FLUSH));
    m_flush();
    check_writes("auto_flush");

    // Reset in the middle of an issued write.
    busy_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 25'h38 + 25'(2 * i);
      write_hw(a, 16'h7000 + 16'(i), lat);
    end
    @(negedge clk_sys); reset = 1'b1; we_req = 1'b0;
    @(posedge clk_sys); #1;
    chk("rst_issue_we",   64'(DDRAM_WE), 64'd0);
    chk("rst_issue_ack",  64'(we_ack), 64'd0);
    chk("rst_issue_idle", 64'(idle), 64'd1);
    chk("rst_issue_be",   64'(DDRAM_BE), 64'd0);
    @(negedge clk_sys); reset = 1'b0; busy_force = 1'b0;
    m_reset(); exp_q.delete();
    write_hw(25'h70, 16'h7777, lat); m_write(25'h70, 16'h7777);
    chk("post_rst_lat", 64'(lat), 64'd1);
    pulse_flush(); m_flush();
    check_writes("post_reset");

    // Same lane written twice: last write wins.
    write_hw(25'h40, 16'hAAAA, lat); m_write(25'h40, 16'hAAAA);
    write_hw(25'h40, 16'hBBBB, lat); m_write(25'h40, 16'hBBBB);
    chk("same_lane_lat", 64'(lat), 64'd1);
    pulse_flush(); m_flush();
    check_writes("same_lane");

    // Flush in IDLE produces nothing.
    pulse_flush();
    check_writes("flush_idle");

    // Flush coinciding with a same-line request: request included in the flushed line.
    write_hw(25'h50, 16'h1234, lat); m_write(25'h50, 16'h1234);
    @(negedge clk_sys);
    wraddr = 25'h52; din = 16'h5678; we_req = ~we_req; flush = 1'b1;
    @(negedge clk_sys); flush = 1'b0;
    chk("coinc_ack", 64'(we_ack), 64'(we_req));
    m_write(25'h52, 16'h5678); m_flush();
    check_writes("coincide");

    // Randomized traffic with random backpressure.
    busy_rand = 1'b1;
    for (int op = 0; op < 300; op++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse_flush(); m_flush();
      end else begin
        a[24:3] = 22'($urandom_range(0, 2)) + ((op < 150) ? 22'd0 : 22'h3FFFFD);
        a[2:0]  = 3'($urandom_range(0, 7));
        d = 16'($urandom);
        begin
          logic hit;
          hit = m_open && a[24:3] == m_line;
          write_hw(a, d, lat);
          if (hit) chk("rand_hit_lat", 64'(lat), 64'd1);
        end
        m_write(a, d);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk_sys);
      if (exp_q.size() > 8) check_writes("rand");
    end
    pulse_flush(); m_flush();
    check_writes("rand_final");
    busy_rand = 1'b0;
    @(negedge clk_sys); @(negedge clk_sys);
    chk("final_idle", 64'(idle), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
